// File: rtl/addsub_16bit_serial_if.sv
// Operand/result bundle for the nibble-serial saturating add/subtract unit.
// Master issues requests, slave (the unit) returns status and results.
interface addsub_16bit_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Ovfl;
    logic             Z;
    logic             N;

    modport master (
        output start, A, B, sub,
        input  busy, done, Sum, Ovfl, Z, N
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, Sum, Ovfl, Z, N
    );
endinterface

// File: rtl/addsub_16bit_serial.sv
// Multi-cycle saturating add/subtract: one 4-bit nibble per cycle with a registered
// inter-nibble carry, then signed saturation and Z/N flags on the edge into StDone.
module addsub_16bit_serial #(
    parameter int unsigned WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    addsub_16bit_serial_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  bx_q, bx_d;
    logic [WIDTH-1:0]  partial_q, partial_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              ovfl_q, ovfl_d;
    logic              z_q, z_d;
    logic              n_q, n_d;

    logic              accept;
    logic              last_nib;
    logic [3:0]        a_nib, b_nib;
    logic [4:0]        nib_sum;
    logic              v;

    // A new request is taken in IDLE and also in DONE, giving back-to-back issue.
    assign accept   = bus.start && (state_q != StRun);
    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_nib) state_d = StDone;
            StDone:  state_d = accept ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StDone);
    end

    assign bus.Sum  = sum_q;
    assign bus.Ovfl = ovfl_q;
    assign bus.Z    = z_q;
    assign bus.N    = n_q;

    // Nibble adder; partial_d already holds the full raw result on the last step.
    always_comb begin
        a_nib     = '0;
        b_nib     = '0;
        partial_d = partial_q;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = bx_q[4*i +: 4];
            end
        end
        nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) partial_d[4*i +: 4] = nib_sum[3:0];
        end
    end

    assign v = ~(a_q[WIDTH-1] ^ bx_q[WIDTH-1]) & (a_q[WIDTH-1] ^ partial_d[WIDTH-1]);

    always_comb begin
        a_d     = a_q;
        bx_d    = bx_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        z_d     = z_q;
        n_d     = n_q;
        if (accept) begin
            a_d     = bus.A;
            bx_d    = bus.B ^ {WIDTH{bus.sub}};
            carry_d = bus.sub;
            idx_d   = '0;
        end else if (state_q == StRun) begin
            carry_d = nib_sum[4];
            idx_d   = idx_q + IDXW'(1);
            if (last_nib) begin
                if (v) sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
                else   sum_d = partial_d;
                ovfl_d = v;
                z_d    = (sum_d == '0);
                n_d    = sum_d[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            bx_q      <= '0;
            partial_q <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            sum_q     <= '0;
            ovfl_q    <= 1'b0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            a_q       <= a_d;
            bx_q      <= bx_d;
            partial_q <= (state_q == StRun) ? partial_d : partial_q;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            sum_q     <= sum_d;
            ovfl_q    <= ovfl_d;
            z_q       <= z_d;
            n_q       <= n_d;
        end
    end
endmodule
